// File: rtl/vector_lane_scheduler_if.sv
// rtl/vector_lane_scheduler_if.sv - lane ALU bus between the vector scheduler and its lane ALUs
interface vector_lane_scheduler_if #(
  parameter int L     = 8,
  parameter int LANES = 4
);
  logic [LANES*L-1:0] lane_a_o;
  logic [LANES*L-1:0] lane_b_o;
  logic [LANES-1:0]   lane_valid_o;
  logic [LANES*L-1:0] lane_res_i;

  modport master (
    output lane_a_o,
    output lane_b_o,
    output lane_valid_o,
    input  lane_res_i
  );

  modport slave (
    input  lane_a_o,
    input  lane_b_o,
    input  lane_valid_o,
    output lane_res_i
  );
endinterface

// File: rtl/vector_lane_scheduler.sv
// rtl/vector_lane_scheduler.sv - issues a V-element vector op one LANES-wide slice per beat and gathers results
module vector_lane_scheduler #(
  parameter int L     = 8,
  parameter int V     = 20,
  parameter int LANES = 4,
  parameter int BEATS = (V + LANES - 1) / LANES,
  parameter int BW    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    start_i,
  input  logic [1:0]              op_type_i,
  input  logic [V*L-1:0]          vec_a_i,
  input  logic [V*L-1:0]          vec_b_i,
  input  logic [L-1:0]            scalar_i,
  input  logic                    flush_i,
  input  logic                    ack_i,
  vector_lane_scheduler_if.master lane_if,
  output logic [V*L-1:0]          result_o,
  output logic [BW-1:0]           beat_o,
  output logic                    busy_o,
  output logic                    done_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);
  localparam int            EW        = (V * L > 1) ? $clog2(V * L) : 1;

  state_t         state_q;
  logic [BW-1:0]  beat_q;
  logic [V*L-1:0] a_q;
  logic [V*L-1:0] b_q;
  logic [V*L-1:0] result_q;
  logic           busy_q;
  logic           done_q;

  logic           accept_d;
  logic           vec_op_d;
  logic [V*L-1:0] b_d;

  logic [LANES-1:0] lane_ok;
  logic [EW-1:0]    lane_base [LANES];

  // A new op is taken from IDLE, or from DONE only when the consumer acks in the same cycle.
  assign accept_d = start_i && ((state_q == S_IDLE) || ((state_q == S_DONE) && ack_i));
  assign vec_op_d = (op_type_i == 2'b01) || (op_type_i == 2'b10);
  assign b_d      = (op_type_i == 2'b01) ? vec_b_i : {V{scalar_i}};

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    int raw_elem;

    assign raw_elem     = int'(beat_q) * LANES + j;
    assign lane_ok[j]   = (state_q == S_ISSUE) && (raw_elem < V);
    assign lane_base[j] = lane_ok[j] ? EW'(raw_elem * L) : '0;

    assign lane_if.lane_valid_o[j]       = lane_ok[j];
    assign lane_if.lane_a_o[j*L +: L]    = lane_ok[j] ? a_q[lane_base[j] +: L] : '0;
    assign lane_if.lane_b_o[j*L +: L]    = lane_ok[j] ? b_q[lane_base[j] +: L] : '0;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= S_IDLE;
      beat_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (flush_i) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (accept_d) begin
      beat_q <= '0;
      if (vec_op_d) begin
        state_q  <= S_ISSUE;
        a_q      <= vec_a_i;
        b_q      <= b_d;
        result_q <= '0;
        busy_q   <= 1'b1;
        done_q   <= 1'b0;
      end else begin
        // Scalar/reserved ops have no vector work: report completion and keep the old result.
        state_q <= S_DONE;
        busy_q  <= 1'b0;
        done_q  <= 1'b1;
      end
    end else begin
      case (state_q)
        S_ISSUE: begin
          for (int j = 0; j < LANES; j++) begin
            if (lane_ok[j]) begin
              result_q[lane_base[j] +: L] <= lane_if.lane_res_i[j*L +: L];
            end
          end
          if (beat_q == BEAT_LAST) begin
            state_q <= S_DONE;
            beat_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            beat_q <= beat_q + 1'b1;
          end
        end
        S_DONE: begin
          if (ack_i) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign result_o = result_q;
  assign beat_o   = beat_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;

endmodule

// File: tb/tb_vector_lane_scheduler.sv
// tb/tb_vector_lane_scheduler.sv - randomized bench for V=20 and V=18 schedulers against a behavioural model
module tb_vector_lane_scheduler;

  localparam int IDLE  = 0;
  localparam int ISSUE = 1;
  localparam int DONE  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic         start, flush, ack;
  logic [1:0]   op;
  logic [159:0] vec_a, vec_b;
  logic [7:0]   scalar;
  logic         chk_en = 1'b0;

  logic [159:0] res0;
  logic [143:0] res1;
  logic [2:0]   beat0, beat1;
  logic         busy0, busy1, done0, done1;

  logic [159:0] act_res [2];
  logic [31:0]  act_la [2];
  logic [31:0]  act_lb [2];
  logic [3:0]   act_lv [2];
  logic [2:0]   act_beat [2];
  logic         busy_w [2];
  logic         done_w [2];

  int n_cmp = 0;
  int n_bad = 0;

  vector_lane_scheduler_if #(.L(8), .LANES(4)) lif0 ();
  vector_lane_scheduler_if #(.L(8), .LANES(4)) lif1 ();

  for (genvar j = 0; j < 4; j++) begin : g_alu
    assign lif0.lane_res_i[j*8 +: 8] = lif0.lane_a_o[j*8 +: 8] + lif0.lane_b_o[j*8 +: 8];
    assign lif1.lane_res_i[j*8 +: 8] = lif1.lane_a_o[j*8 +: 8] + lif1.lane_b_o[j*8 +: 8];
  end

  vector_lane_scheduler #(.L(8), .V(20), .LANES(4)) u_dut (
    .CLK(clk), .RST(rst_n), .start_i(start), .op_type_i(op),
    .vec_a_i(vec_a), .vec_b_i(vec_b), .scalar_i(scalar), .flush_i(flush), .ack_i(ack),
    .lane_if(lif0), .result_o(res0), .beat_o(beat0), .busy_o(busy0), .done_o(done0)
  );

  vector_lane_scheduler #(.L(8), .V(18), .LANES(4)) u_dut18 (
    .CLK(clk), .RST(rst_n), .start_i(start), .op_type_i(op),
    .vec_a_i(vec_a[143:0]), .vec_b_i(vec_b[143:0]), .scalar_i(scalar), .flush_i(flush), .ack_i(ack),
    .lane_if(lif1), .result_o(res1), .beat_o(beat1), .busy_o(busy1), .done_o(done1)
  );

  assign act_res[0]  = res0;
  assign act_res[1]  = {16'h0, res1};
  assign act_la[0]   = lif0.lane_a_o;
  assign act_la[1]   = lif1.lane_a_o;
  assign act_lb[0]   = lif0.lane_b_o;
  assign act_lb[1]   = lif1.lane_b_o;
  assign act_lv[0]   = lif0.lane_valid_o;
  assign act_lv[1]   = lif1.lane_valid_o;
  assign act_beat[0] = beat0;
  assign act_beat[1] = beat1;
  assign busy_w[0]   = busy0;
  assign busy_w[1]   = busy1;
  assign done_w[0]   = done0;
  assign done_w[1]   = done1;

  // Reference model: per instance, the operation phase, current slice and element arrays.
  int         m_st [2];
  int         m_beat [2];
  logic [7:0] m_a [2][20];
  logic [7:0] m_b [2][20];
  logic [7:0] m_r [2][20];

  function automatic int nv(int d);
    return (d == 0) ? 20 : 18;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        m_st[d]   <= IDLE;
        m_beat[d] <= 0;
        for (int i = 0; i < 20; i++) begin
          m_a[d][i] <= 8'h00;
          m_b[d][i] <= 8'h00;
          m_r[d][i] <= 8'h00;
        end
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (flush) begin
          m_st[d]   <= IDLE;
          m_beat[d] <= 0;
        end else if (start && (m_st[d] == IDLE || (m_st[d] == DONE && ack))) begin
          if (op == 2'b01 || op == 2'b10) begin
            for (int i = 0; i < 20; i++) begin
              m_a[d][i] <= vec_a[i*8 +: 8];
              m_b[d][i] <= (op == 2'b01) ? vec_b[i*8 +: 8] : scalar;
              m_r[d][i] <= 8'h00;
            end
            m_st[d]   <= ISSUE;
            m_beat[d] <= 0;
          end else begin
            m_st[d] <= DONE;
          end
        end else if (m_st[d] == ISSUE) begin
          for (int i = 0; i < nv(d); i++) begin
            if (i / 4 == m_beat[d]) m_r[d][i] <= m_a[d][i] + m_b[d][i];
          end
          if (m_beat[d] == (nv(d) + 3) / 4 - 1) m_st[d] <= DONE;
          else m_beat[d] <= m_beat[d] + 1;
        end else if (m_st[d] == DONE && ack) begin
          m_st[d] <= IDLE;
        end
      end
    end
  end

  function automatic logic [3:0] exp_valid(int d);
    logic [3:0] v = '0;
    if (m_st[d] == ISSUE)
      for (int j = 0; j < 4; j++) v[j] = (m_beat[d] * 4 + j < nv(d));
    return v;
  endfunction

  function automatic logic [31:0] exp_lane(int d, bit side_b);
    logic [31:0] r = '0;
    logic [3:0]  v = exp_valid(d);
    for (int j = 0; j < 4; j++)
      if (v[j]) r[j*8 +: 8] = side_b ? m_b[d][m_beat[d]*4 + j] : m_a[d][m_beat[d]*4 + j];
    return r;
  endfunction

  function automatic logic [159:0] exp_result(int d);
    logic [159:0] r = '0;
    for (int i = 0; i < nv(d); i++) r[i*8 +: 8] = m_r[d][i];
    return r;
  endfunction

  task automatic check(string name, logic [159:0] act, logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("busy[%0d]", d), busy_w[d], m_st[d] == ISSUE);
        check($sformatf("done[%0d]", d), done_w[d], m_st[d] == DONE);
        check($sformatf("lane_valid[%0d]", d), act_lv[d], exp_valid(d));
        check($sformatf("lane_a[%0d]", d), act_la[d], exp_lane(d, 1'b0));
        check($sformatf("lane_b[%0d]", d), act_lb[d], exp_lane(d, 1'b1));
        check($sformatf("result[%0d]", d), act_res[d], exp_result(d));
        if (m_st[d] == ISSUE) check($sformatf("beat[%0d]", d), act_beat[d], m_beat[d]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_vecs();
    for (int i = 0; i < 20; i++) begin
      vec_a[i*8 +: 8] = 8'($urandom);
      vec_b[i*8 +: 8] = 8'($urandom);
    end
  endtask

  task automatic wait_done(string name);
    int c = 0;
    @(negedge clk);
    while (!done_w[0] && c < 40) begin
      @(negedge clk);
      c++;
    end
    check(name, done_w[0], 1'b1);
  endtask

  logic [159:0] exp_v, saved, xa, xb;

  initial begin
    start = 0; flush = 0; ack = 0; op = 2'b00; vec_a = '0; vec_b = '0; scalar = 8'h00;
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy_w[0], 1'b0);
    check("rst_done", done_w[0], 1'b0);
    check("rst_result", act_res[0], '0);
    check("rst_lane_valid", act_lv[0], 4'h0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("idle_done", done_w[0], 1'b0);
    check("idle_busy", busy_w[0], 1'b0);

    // Vector-vector add with A[i]=i, B[i]=10
    for (int i = 0; i < 20; i++) begin
      vec_a[i*8 +: 8] = 8'(i);
      vec_b[i*8 +: 8] = 8'd10;
    end
    op = 2'b01; start = 1; tick(); start = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check($sformatf("vv_busy_c%0d", k), busy_w[0], k <= 5);
      check($sformatf("vv_done_c%0d", k), done_w[0], k == 6);
      if (k <= 5) begin
        check($sformatf("vv_beat_c%0d", k), act_beat[0], k - 1);
        check($sformatf("vv_valid_c%0d", k), act_lv[0], 4'b1111);
      end
      if (k == 5) begin
        check("v18_last_valid", act_lv[1], 4'b0011);
        check("v18_last_a_hi", act_la[1][31:16], 16'h0);
        check("v18_last_b_hi", act_lb[1][31:16], 16'h0);
      end
    end
    exp_v = '0;
    for (int i = 0; i < 20; i++) exp_v[i*8 +: 8] = 8'(i + 10);
    check("vv_result", act_res[0], exp_v);
    check("vv_elem7", act_res[0][56 +: 8], 8'd17);
    check("v18_result", act_res[1], {16'h0, exp_v[143:0]});
    ack = 1; tick(); ack = 0;

    // Vector-scalar with operands changing mid-op
    for (int i = 0; i < 20; i++) vec_a[i*8 +: 8] = 8'(2 * i);
    scalar = 8'd3; op = 2'b10; start = 1; tick(); start = 0;
    tick(); tick();
    rand_vecs(); scalar = 8'hA5;
    wait_done("vs_done");
    exp_v = '0;
    for (int i = 0; i < 20; i++) exp_v[i*8 +: 8] = 8'(2 * i + 3);
    check("vs_result", act_res[0], exp_v);
    check("vs_elem5", act_res[0][40 +: 8], 8'd13);
    ack = 1; tick(); ack = 0;

    // Flush at beat 2
    rand_vecs(); op = 2'b01; start = 1; tick(); start = 0;
    tick(); tick();
    flush = 1; tick(); flush = 0;
    @(negedge clk);
    check("flush_busy", busy_w[0], 1'b0);
    check("flush_done", done_w[0], 1'b0);
    check("flush_elems_12_19", act_res[0][159:96], 64'h0);
    repeat (3) begin
      tick();
      @(negedge clk);
      check("flush_no_done", done_w[0], 1'b0);
    end

    // start during ISSUE is ignored
    rand_vecs(); xa = vec_a; xb = vec_b;
    op = 2'b01; start = 1; tick();
    rand_vecs(); op = 2'b10; tick(); tick(); start = 0;
    wait_done("ign_done");
    exp_v = '0;
    for (int i = 0; i < 20; i++) exp_v[i*8 +: 8] = xa[i*8 +: 8] + xb[i*8 +: 8];
    check("ign_result", act_res[0], exp_v);

    // DONE holds without ack, start alone ignored
    saved = act_res[0];
    op = 2'b01; start = 1; rand_vecs();
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge clk);
      check("hold_done", done_w[0], 1'b1);
      check("hold_result", act_res[0], saved);
    end
    ack = 1; start = 1; op = 2'b01; tick(); ack = 0; start = 0;
    @(negedge clk);
    check("b2b_busy", busy_w[0], 1'b1);
    check("b2b_beat", act_beat[0], 3'd0);
    wait_done("b2b_done");
    saved = act_res[0];
    ack = 1; start = 1; op = 2'b00; tick(); ack = 0; start = 0;
    @(negedge clk);
    check("scalar_done", done_w[0], 1'b1);
    check("scalar_busy", busy_w[0], 1'b0);
    check("scalar_result", act_res[0], saved);
    ack = 1; start = 1; op = 2'b11; tick(); ack = 0; start = 0;
    @(negedge clk);
    check("rsvd_done", done_w[0], 1'b1);
    ack = 1; tick(); ack = 0;

    // Reset in the middle of ISSUE
    rand_vecs(); op = 2'b01; start = 1; tick(); start = 0;
    tick();
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", busy_w[0], 1'b0);
    check("rst_mid_result", act_res[0], '0);
    check("rst_mid_valid", act_lv[0], 4'h0);
    tick();
    rst_n = 1'b1;

    for (int n = 0; n < 400; n++) begin
      start  = ($urandom_range(0, 2) == 0);
      op     = 2'($urandom);
      ack    = 1'($urandom_range(0, 1));
      flush  = ($urandom_range(0, 24) == 0);
      scalar = 8'($urandom);
      if ($urandom_range(0, 3) == 0) rand_vecs();
      tick();
    end
    start = 0; ack = 0; flush = 0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary in time");
    $fatal(1);
  end

endmodule
